// File: rtl/bp_be_pkg.sv
// Shared types for the BE-side FE command director: director FSM states and the
// fe_cmd / fe_queue packet layouts exchanged with the front end.
package bp_be_pkg;

    localparam int unsigned vaddr_width_p               = 39;
    localparam int unsigned branch_metadata_fwd_width_p = 16;

    typedef enum logic [1:0] {
        e_reset,
        e_boot,
        e_run,
        e_flush
    } bp_be_director_state_e;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence         = 3'd3,
        e_op_wait                 = 3'd4,
        e_op_attaboy              = 3'd5
    } bp_fe_cmd_opcode_e;

    localparam logic [1:0] priv_machine_lp = 2'b11;

    typedef struct packed {
        bp_fe_cmd_opcode_e                       opcode;
        logic [vaddr_width_p-1:0]                npc;
        logic [1:0]                              priv;
        logic                                    translation_en;
        logic                                    branch_taken;
        logic [branch_metadata_fwd_width_p-1:0]  branch_md;
    } bp_fe_cmd_s;

    typedef struct packed {
        logic [vaddr_width_p-1:0]                pc;
        logic [31:0]                             instr;
        logic [branch_metadata_fwd_width_p-1:0]  branch_md;
    } bp_fe_queue_s;

    localparam int unsigned fe_cmd_width_lp   = $bits(bp_fe_cmd_s);
    localparam int unsigned fe_queue_width_lp = $bits(bp_fe_queue_s);

    function automatic bp_fe_cmd_s make_attaboy(
        input logic [vaddr_width_p-1:0]               pc,
        input logic                                   taken,
        input logic [branch_metadata_fwd_width_p-1:0] md
    );
        bp_fe_cmd_s c;
        c              = '0;
        c.opcode       = e_op_attaboy;
        c.npc          = pc;
        c.branch_taken = taken;
        c.branch_md    = md;
        return c;
    endfunction

endpackage

// File: rtl/bp_be_cmd_fifo_async.sv
// Single-read single-write command FIFO with asynchronous active-low reset.
// Reports full, empty and the number of free slots; head reads as zero when empty.
module bp_be_cmd_fifo_async #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 8,
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1),
    localparam int unsigned ptr_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    yumi_i,
    output logic [width_p-1:0]      data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [cnt_width_lp-1:0] free_o
);

    logic [width_p-1:0]      r_mem [els_p];
    logic [ptr_width_lp-1:0] r_wptr, r_rptr;
    logic [cnt_width_lp-1:0] r_count;
    logic                    w_enq, w_deq;

    always_comb begin
        full_o  = (r_count == cnt_width_lp'(els_p));
        empty_o = (r_count == '0);
        free_o  = cnt_width_lp'(els_p) - r_count;
        w_enq   = v_i & ~full_o;
        w_deq   = yumi_i & ~empty_o;
        data_o  = empty_o ? '0 : r_mem[r_rptr];
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Depth is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + ptr_width_lp'(1);
            if (w_deq) r_rptr <= r_rptr + ptr_width_lp'(1);
            if (w_enq && !w_deq) begin
                r_count <= r_count + cnt_width_lp'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - cnt_width_lp'(1);
            end
        end
    end

    a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(v_i && full_o));

endmodule

// File: rtl/bp_be_fe_cmd_director.sv
// BE-side FE command director: buffers fetch entries for issue, builds the FE command
// stream (boot state_reset, BE commands, attaboys) and flushes stale fetches on redirect.
module bp_be_fe_cmd_director
    import bp_be_pkg::*;
#(
    parameter int unsigned              cmd_els_p = 4,
    parameter logic [vaddr_width_p-1:0] boot_pc_p = 39'h0011_0000
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [fe_queue_width_lp-1:0]           fe_queue_i,
    input  logic                                   fe_queue_v_i,
    output logic                                   fe_queue_ready_and_o,
    output logic [fe_queue_width_lp-1:0]           fetch_pkt_o,
    output logic                                   fetch_v_o,
    input  logic                                   fetch_yumi_i,
    input  logic [fe_cmd_width_lp-1:0]             cmd_i,
    input  logic                                   cmd_v_i,
    output logic                                   cmd_ready_and_o,
    input  logic                                   attaboy_v_i,
    input  logic [vaddr_width_p-1:0]               attaboy_pc_i,
    input  logic                                   attaboy_taken_i,
    input  logic [branch_metadata_fwd_width_p-1:0] attaboy_md_i,
    output logic                                   attaboy_drop_o,
    output logic [fe_cmd_width_lp-1:0]             fe_cmd_o,
    output logic                                   fe_cmd_v_o,
    input  logic                                   fe_cmd_yumi_i,
    output logic                                   flush_pending_o
);

    localparam int unsigned cnt_width_lp = $clog2(cmd_els_p + 1);

    bp_be_director_state_e   r_state;
    logic [cnt_width_lp-1:0] r_flush_cnt, w_flush_cnt_d, w_free;
    logic                    r_buf_v;
    bp_fe_queue_s            r_buf;

    logic w_full, w_empty, w_active, w_boot_enq, w_cmd_acc, w_att_enq;
    logic w_nonatt_enq, w_nonatt_deq, w_fifo_v, w_discard, w_fq_acc;
    bp_fe_cmd_s w_fifo_wdata, w_head;

    always_comb begin
        w_active        = (r_state == e_run) || (r_state == e_flush);
        w_boot_enq      = (r_state == e_boot);
        cmd_ready_and_o = w_active & ~w_full;
        w_cmd_acc       = cmd_v_i & cmd_ready_and_o;
        // The last free slot is kept for a redirect; attaboys are only hints.
        w_att_enq       = attaboy_v_i & w_active & ~w_cmd_acc
                        & (w_free >= cnt_width_lp'(2));
        attaboy_drop_o  = attaboy_v_i & ~w_att_enq & (r_state != e_reset);
        w_nonatt_enq    = w_boot_enq | w_cmd_acc;
        w_nonatt_deq    = fe_cmd_yumi_i & ~w_empty & (w_head.opcode != e_op_attaboy);
        w_fifo_v        = w_nonatt_enq | w_att_enq;

        w_fifo_wdata = '0;
        if (w_boot_enq) begin
            w_fifo_wdata.opcode = e_op_state_reset;
            w_fifo_wdata.npc    = boot_pc_p;
            w_fifo_wdata.priv   = priv_machine_lp;
        end else if (w_cmd_acc) begin
            w_fifo_wdata = bp_fe_cmd_s'(cmd_i);
        end else begin
            w_fifo_wdata = make_attaboy(attaboy_pc_i, attaboy_taken_i, attaboy_md_i);
        end

        unique case ({w_nonatt_enq, w_nonatt_deq})
            2'b10:   w_flush_cnt_d = r_flush_cnt + cnt_width_lp'(1);
            2'b01:   w_flush_cnt_d = r_flush_cnt - cnt_width_lp'(1);
            default: w_flush_cnt_d = r_flush_cnt;
        endcase

        w_discard            = (r_state == e_flush) | w_nonatt_enq;
        fe_queue_ready_and_o = (r_state != e_reset) & (~r_buf_v | w_discard);
        w_fq_acc             = fe_queue_v_i & fe_queue_ready_and_o;
        fetch_v_o            = r_buf_v & ~w_discard;
        fetch_pkt_o          = r_buf;
        flush_pending_o      = (r_flush_cnt != '0);
        fe_cmd_o             = w_head;
        fe_cmd_v_o           = ~w_empty;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= e_reset;
            r_flush_cnt <= '0;
            r_buf_v     <= 1'b0;
            r_buf       <= '0;
        end else begin
            r_flush_cnt <= w_flush_cnt_d;
            case (r_state)
                e_reset: r_state <= e_boot;
                e_boot:  r_state <= e_flush;
                default: r_state <= (w_flush_cnt_d != '0) ? e_flush : e_run;
            endcase
            if (w_discard) begin
                r_buf_v <= 1'b0;
            end else if (w_fq_acc) begin
                r_buf_v <= 1'b1;
                r_buf   <= bp_fe_queue_s'(fe_queue_i);
            end else if (fetch_yumi_i) begin
                r_buf_v <= 1'b0;
            end
        end
    end

    bp_be_cmd_fifo_async #(
        .els_p   (cmd_els_p),
        .width_p (fe_cmd_width_lp)
    ) u_cmd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (w_fifo_v),
        .data_i    (w_fifo_wdata),
        .yumi_i    (fe_cmd_yumi_i),
        .data_o    (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .free_o    (w_free)
    );

    a_yumi_needs_entry: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fetch_yumi_i && !r_buf_v));

endmodule

// File: tb/tb_bp_be_fe_cmd_director.sv
// Directed bench for bp_be_fe_cmd_director: boot, fetch path, redirect flush,
// FIFO backpressure, attaboy drop rules and mid-flush reset.
module tb_bp_be_fe_cmd_director;
    import bp_be_pkg::*;

    logic clk_i = 1'b0;
    logic reset_n_i;
    bp_fe_queue_s fq_in;
    logic fe_queue_v_i, fe_queue_ready_and_o;
    bp_fe_queue_s fetch_pkt;
    logic fetch_v_o, fetch_yumi_i;
    bp_fe_cmd_s cmd_in;
    logic cmd_v_i, cmd_ready_and_o;
    logic attaboy_v_i, attaboy_taken_i, attaboy_drop_o;
    logic [vaddr_width_p-1:0] attaboy_pc_i;
    logic [branch_metadata_fwd_width_p-1:0] attaboy_md_i;
    bp_fe_cmd_s fe_cmd;
    logic fe_cmd_v_o, fe_cmd_yumi_i, flush_pending_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    bp_be_fe_cmd_director #(
        .cmd_els_p (4),
        .boot_pc_p (39'h0011_0000)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .fe_queue_i           (fq_in),
        .fe_queue_v_i         (fe_queue_v_i),
        .fe_queue_ready_and_o (fe_queue_ready_and_o),
        .fetch_pkt_o          (fetch_pkt),
        .fetch_v_o            (fetch_v_o),
        .fetch_yumi_i         (fetch_yumi_i),
        .cmd_i                (cmd_in),
        .cmd_v_i              (cmd_v_i),
        .cmd_ready_and_o      (cmd_ready_and_o),
        .attaboy_v_i          (attaboy_v_i),
        .attaboy_pc_i         (attaboy_pc_i),
        .attaboy_taken_i      (attaboy_taken_i),
        .attaboy_md_i         (attaboy_md_i),
        .attaboy_drop_o       (attaboy_drop_o),
        .fe_cmd_o             (fe_cmd),
        .fe_cmd_v_o           (fe_cmd_v_o),
        .fe_cmd_yumi_i        (fe_cmd_yumi_i),
        .flush_pending_o      (flush_pending_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic bp_fe_cmd_s mk_cmd(input bp_fe_cmd_opcode_e op,
                                           input logic [vaddr_width_p-1:0] npc);
        bp_fe_cmd_s c;
        c        = '0;
        c.opcode = op;
        c.npc    = npc;
        return c;
    endfunction

    task automatic set_fq(input logic v, input logic [vaddr_width_p-1:0] pc);
        fe_queue_v_i    = v;
        fq_in           = '0;
        fq_in.pc        = pc;
        fq_in.instr     = 32'h0000_0013 | {pc[15:0], 16'h0};
    endtask

    // Entered at a clock low phase with reset just released.
    task automatic do_boot(input string tag);
        tick; #1;
        chk({tag, "_v_cycle1"}, fe_cmd_v_o, 1'b0);
        tick; #1;
        chk({tag, "_v_cycle2"}, fe_cmd_v_o, 1'b1);
        chk({tag, "_opcode"}, fe_cmd.opcode, e_op_state_reset);
        chk({tag, "_npc"}, fe_cmd.npc, 39'h0011_0000);
        chk({tag, "_priv"}, fe_cmd.priv, 2'b11);
        chk({tag, "_xlate"}, fe_cmd.translation_en, 1'b0);
        chk({tag, "_pending"}, flush_pending_o, 1'b1);
        fe_cmd_yumi_i = 1'b1;
        tick;
        fe_cmd_yumi_i = 1'b0;
        #1;
        chk({tag, "_pending_clr"}, flush_pending_o, 1'b0);
        chk({tag, "_v_clr"}, fe_cmd_v_o, 1'b0);
        chk({tag, "_cmd_ready"}, cmd_ready_and_o, 1'b1);
    endtask

    initial begin
        reset_n_i       = 1'b0;
        set_fq(1'b0, '0);
        fetch_yumi_i    = 1'b0;
        cmd_in          = '0;
        cmd_v_i         = 1'b0;
        attaboy_v_i     = 1'b0;
        attaboy_pc_i    = '0;
        attaboy_taken_i = 1'b0;
        attaboy_md_i    = '0;
        fe_cmd_yumi_i   = 1'b0;

        @(negedge clk_i); #1;
        chk("rst_fe_cmd_v", fe_cmd_v_o, 1'b0);
        chk("rst_fetch_v", fetch_v_o, 1'b0);
        chk("rst_cmd_ready", cmd_ready_and_o, 1'b0);
        chk("rst_fq_ready", fe_queue_ready_and_o, 1'b0);
        chk("rst_pending", flush_pending_o, 1'b0);
        chk("rst_drop", attaboy_drop_o, 1'b0);
        chk("rst_fe_cmd", fe_cmd, '0);

        reset_n_i = 1'b1;
        do_boot("boot");

        // Fetch path: one-cycle latency, in order.
        for (int i = 0; i < 3; i++) begin
            set_fq(1'b1, 39'h100 + 39'(4 * i));
            #1;
            chk("fetch_fq_ready", fe_queue_ready_and_o, 1'b1);
            chk("fetch_v_empty", fetch_v_o, 1'b0);
            tick;
            set_fq(1'b0, '0);
            #1;
            chk("fetch_v_full", fetch_v_o, 1'b1);
            chk("fetch_pc", fetch_pkt.pc, 39'h100 + 39'(4 * i));
            fetch_yumi_i = 1'b1;
            tick;
            fetch_yumi_i = 1'b0;
        end

        // Redirect with 0x104 buffered.
        set_fq(1'b1, 39'h104);
        tick;
        set_fq(1'b0, '0);
        #1;
        chk("hold_v0", fetch_v_o, 1'b1);
        tick; #1;
        chk("hold_v1", fetch_v_o, 1'b1);
        chk("hold_pc", fetch_pkt.pc, 39'h104);
        chk("hold_fq_busy", fe_queue_ready_and_o, 1'b0);
        cmd_in  = mk_cmd(e_op_pc_redirection, 39'h2000);
        cmd_v_i = 1'b1;
        set_fq(1'b1, 39'h108);
        #1;
        chk("redir_cmd_ready", cmd_ready_and_o, 1'b1);
        chk("redir_fetch_v", fetch_v_o, 1'b0);
        chk("redir_fq_ready", fe_queue_ready_and_o, 1'b1);
        tick;
        cmd_v_i = 1'b0;
        set_fq(1'b1, 39'h10c);
        #1;
        chk("flush_fetch_v", fetch_v_o, 1'b0);
        chk("flush_cmd_v", fe_cmd_v_o, 1'b1);
        chk("flush_opcode", fe_cmd.opcode, e_op_pc_redirection);
        chk("flush_npc", fe_cmd.npc, 39'h2000);
        chk("flush_pending", flush_pending_o, 1'b1);
        chk("flush_fq_ready", fe_queue_ready_and_o, 1'b1);
        tick;
        set_fq(1'b1, 39'h110);
        fe_cmd_yumi_i = 1'b1;
        #1;
        chk("flush_fetch_v2", fetch_v_o, 1'b0);
        tick;
        fe_cmd_yumi_i = 1'b0;
        set_fq(1'b1, 39'h114);
        #1;
        chk("unflush_pending", flush_pending_o, 1'b0);
        chk("unflush_fetch_v", fetch_v_o, 1'b0);
        tick;
        set_fq(1'b0, '0);
        #1;
        chk("post_redir_v", fetch_v_o, 1'b1);
        chk("post_redir_pc", fetch_pkt.pc, 39'h114);
        fetch_yumi_i = 1'b1;
        tick;
        fetch_yumi_i = 1'b0;
        #1;
        chk("post_redir_drained", fetch_v_o, 1'b0);

        // Fill the command FIFO without FE consumption.
        cmd_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_in = mk_cmd(e_op_icache_fence, 39'(i));
            #1;
            chk("fill_ready", cmd_ready_and_o, 1'b1);
            tick;
        end
        cmd_in = mk_cmd(e_op_icache_fence, 39'h4);
        #1;
        chk("full_ready", cmd_ready_and_o, 1'b0);
        chk("full_head", fe_cmd.npc, 39'h0);
        fe_cmd_yumi_i = 1'b1;
        #1;
        chk("full_yumi_ready", cmd_ready_and_o, 1'b0);
        tick;
        cmd_v_i       = 1'b0;
        fe_cmd_yumi_i = 1'b0;
        #1;
        chk("after_yumi_ready", cmd_ready_and_o, 1'b1);
        chk("after_yumi_head", fe_cmd.npc, 39'h1);

        // One free slot: attaboy must be dropped.
        attaboy_v_i  = 1'b1;
        attaboy_pc_i = 39'h200;
        #1;
        chk("att_1free_drop", attaboy_drop_o, 1'b1);
        tick;
        attaboy_v_i = 1'b0;
        #1;
        chk("att_drop_clr", attaboy_drop_o, 1'b0);
        chk("att_1free_head", fe_cmd.npc, 39'h1);
        for (int i = 1; i < 4; i++) begin
            fe_cmd_yumi_i = 1'b1;
            #1;
            chk("drain_head", fe_cmd.npc, 39'(i));
            tick;
        end
        fe_cmd_yumi_i = 1'b0;
        #1;
        chk("drain_v", fe_cmd_v_o, 1'b0);
        chk("drain_pending", flush_pending_o, 1'b0);

        // Command and attaboy together: command wins.
        cmd_in       = mk_cmd(e_op_wait, 39'h0);
        cmd_v_i      = 1'b1;
        attaboy_v_i  = 1'b1;
        attaboy_pc_i = 39'h250;
        #1;
        chk("coll_drop", attaboy_drop_o, 1'b1);
        chk("coll_cmd_ready", cmd_ready_and_o, 1'b1);
        tick;
        cmd_v_i     = 1'b0;
        attaboy_v_i = 1'b0;
        #1;
        chk("coll_opcode", fe_cmd.opcode, e_op_wait);
        chk("coll_pending", flush_pending_o, 1'b1);

        // Attaboy with room is enqueued and does not count as a flush.
        attaboy_v_i     = 1'b1;
        attaboy_pc_i    = 39'h300;
        attaboy_taken_i = 1'b1;
        attaboy_md_i    = 16'hbeef;
        fe_cmd_yumi_i   = 1'b1;
        #1;
        chk("att_ok_drop", attaboy_drop_o, 1'b0);
        tick;
        attaboy_v_i   = 1'b0;
        fe_cmd_yumi_i = 1'b0;
        #1;
        chk("att_v", fe_cmd_v_o, 1'b1);
        chk("att_opcode", fe_cmd.opcode, e_op_attaboy);
        chk("att_pc", fe_cmd.npc, 39'h300);
        chk("att_taken", fe_cmd.branch_taken, 1'b1);
        chk("att_md", fe_cmd.branch_md, 16'hbeef);
        chk("att_pending", flush_pending_o, 1'b0);
        fe_cmd_yumi_i = 1'b1;
        tick;
        fe_cmd_yumi_i = 1'b0;
        #1;
        chk("att_deq_v", fe_cmd_v_o, 1'b0);
        chk("att_deq_pending", flush_pending_o, 1'b0);

        // Reset in the middle of a two-deep flush.
        cmd_v_i = 1'b1;
        cmd_in  = mk_cmd(e_op_pc_redirection, 39'h400);
        tick;
        cmd_in  = mk_cmd(e_op_pc_redirection, 39'h404);
        tick;
        cmd_v_i = 1'b0;
        #1;
        chk("mid_pending", flush_pending_o, 1'b1);
        chk("mid_head", fe_cmd.npc, 39'h400);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_cmd_v", fe_cmd_v_o, 1'b0);
        chk("mid_rst_pending", flush_pending_o, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready_and_o, 1'b0);
        chk("mid_rst_fq_ready", fe_queue_ready_and_o, 1'b0);
        chk("mid_rst_fetch_v", fetch_v_o, 1'b0);
        chk("mid_rst_fe_cmd", fe_cmd, '0);
        tick;
        reset_n_i = 1'b1;
        do_boot("reboot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
